life_grid_reader: RTL and testbench

//  Reader end of the Game of Life grid path: snapshots a 64-bit generation from the evolve

---
 rtl/life_pkg.sv | 18 +
 rtl/row_popcount.sv | 17 +
 rtl/life_grid_reader.sv | 139 +++++++++++++
 tb/tb_life_grid_reader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants and types for the Game of Life grid reader.
// Grid geometry, population width and reader FSM state encoding.
package life_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int GRID_W = ROWS * COLS;
  localparam int POP_W  = 7;
  localparam int IDX_W  = 3;
  localparam int RPOP_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    SUMMARY = 2'd2
  } reader_state_t;

endpackage

// File: rtl/row_popcount.sv
// Combinational live-cell count of one grid row.
// Ports: row_i (COLS cells) -> cnt_o (4-bit count).
module row_popcount
  import life_pkg::*;
(
  input  logic [COLS-1:0]   row_i,
  output logic [RPOP_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < COLS; i++) begin
      cnt_o = cnt_o + RPOP_W'(row_i[i]);
    end
  end

endmodule

// File: rtl/life_grid_reader.sv
// Snapshots a generation and streams it row by row, then a summary.
// Ports: grid/grid_valid in, row_* valid/ready stream out,
// frame_pop/extinct/stable/pop_valid summary, busy, overrun/overrun_clr.
module life_grid_reader
  import life_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [GRID_W-1:0] grid,
  input  logic              grid_valid,
  output logic [COLS-1:0]   row_data,
  output logic [IDX_W-1:0]  row_idx,
  output logic              row_last,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [POP_W-1:0]  frame_pop,
  output logic              extinct,
  output logic              stable,
  output logic              pop_valid,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  reader_state_t     state_q, state_d;
  logic [GRID_W-1:0] snap_q, snap_d;
  logic [GRID_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [IDX_W-1:0]  row_cnt_q, row_cnt_d;
  logic [POP_W-1:0]  pop_acc_q, pop_acc_d;
  logic [POP_W-1:0]  frame_pop_q, frame_pop_d;
  logic              extinct_q, extinct_d;
  logic              stable_q, stable_d;
  logic              overrun_q, overrun_d;
  logic [RPOP_W-1:0] row_pop;
  logic [POP_W-1:0]  pop_sum;
  logic              xfer;

  row_popcount u_pop (
    .row_i (row_data),
    .cnt_o (row_pop)
  );

  assign pop_sum = pop_acc_q + POP_W'(row_pop);
  assign xfer    = row_valid & row_ready;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    row_cnt_d   = row_cnt_q;
    pop_acc_d   = pop_acc_q;
    frame_pop_d = frame_pop_q;
    extinct_d   = extinct_q;
    stable_d    = stable_q;
    overrun_d   = overrun_q;
    row_valid   = 1'b0;
    row_data    = '0;
    row_idx     = '0;
    row_last    = 1'b0;

    // set wins over clear
    if (grid_valid && state_q != IDLE) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (grid_valid) begin
          snap_d    = grid;
          row_cnt_d = '0;
          pop_acc_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        row_valid = 1'b1;
        row_data  = snap_q[row_cnt_q*COLS +: COLS];
        row_idx   = row_cnt_q;
        row_last  = (row_cnt_q == IDX_W'(ROWS-1));
        if (xfer) begin
          pop_acc_d = pop_sum;
          if (row_last) begin
            // summary regs load here so they are visible with pop_valid
            frame_pop_d = pop_sum;
            extinct_d   = (pop_sum == '0);
            stable_d    = have_prev_q & (snap_q == prev_q);
            state_d     = SUMMARY;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      SUMMARY: begin
        prev_d      = snap_q;
        have_prev_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      row_cnt_q   <= '0;
      pop_acc_q   <= '0;
      frame_pop_q <= '0;
      extinct_q   <= 1'b0;
      stable_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      row_cnt_q   <= row_cnt_d;
      pop_acc_q   <= pop_acc_d;
      frame_pop_q <= frame_pop_d;
      extinct_q   <= extinct_d;
      stable_q    <= stable_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pop_valid = (state_q == SUMMARY);
  assign busy      = (state_q != IDLE);
  assign frame_pop = frame_pop_q;
  assign extinct   = extinct_q;
  assign stable    = stable_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_life_grid_reader.sv
// Directed testbench for life_grid_reader.
// Table-driven frames plus overrun and mid-frame reset sequences.
module tb_life_grid_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] grid;
  logic        grid_valid;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_last;
  logic        row_valid;
  logic        row_ready;
  logic [6:0]  frame_pop;
  logic        extinct;
  logic        stable;
  logic        pop_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_grid_reader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .grid        (grid),
    .grid_valid  (grid_valid),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_last    (row_last),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .frame_pop   (frame_pop),
    .extinct     (extinct),
    .stable      (stable),
    .pop_valid   (pop_valid),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  typedef struct {
    logic [63:0] g;
    bit          toggle;
    logic [6:0]  pop;
    bit          ext;
    bit          stb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [63:0] g, input bit toggle,
                           input int inj, input bit inj_clr,
                           input logic [6:0] ep, input bit ee,
                           input bit es);
    int  beat = 0;
    int  k    = 0;
    bit  done = 1'b0;
    logic [7:0] er;
    @(negedge clk);
    grid       = g;
    grid_valid = 1'b1;
    row_ready  = 1'b0;
    @(negedge clk);
    grid_valid = 1'b0;
    grid       = ~g;
    while (!done && k < 40) begin
      row_ready = toggle ? (k % 3 == 0) : 1'b1;
      if (k == inj) begin
        grid_valid  = 1'b1;
        overrun_clr = inj_clr;
      end
      er = g[beat*8 +: 8];
      chk("row_valid", 64'(row_valid), 64'd1);
      chk("row_idx",   64'(row_idx),   64'(beat));
      chk("row_data",  64'(row_data),  64'(er));
      chk("row_last",  64'(row_last),  64'(beat == 7));
      chk("busy",      64'(busy),      64'd1);
      chk("pop_valid_mid", 64'(pop_valid), 64'd0);
      if (row_ready) begin
        if (beat == 7) done = 1'b1;
        beat++;
      end
      k++;
      @(negedge clk);
      grid_valid  = 1'b0;
      overrun_clr = 1'b0;
      if (inj >= 0 && k == inj + 1) begin
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("busy_inj",    64'(busy),    64'd1);
      end
    end
    row_ready = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: got %0d beats expected 8", beat);
    end
    chk("pop_valid", 64'(pop_valid), 64'd1);
    chk("row_valid_sum", 64'(row_valid), 64'd0);
    chk("frame_pop", 64'(frame_pop), 64'(ep));
    chk("extinct",   64'(extinct),   64'(ee));
    chk("stable",    64'(stable),    64'(es));
    @(negedge clk);
    chk("pop_valid_pulse", 64'(pop_valid), 64'd0);
    chk("busy_done",       64'(busy),      64'd0);
    chk("frame_pop_hold",  64'(frame_pop), 64'(ep));
  endtask

  initial begin
    int k;
    vecs[0] = '{64'h0000_0000_0007_0402, 1'b0, 7'd5,  1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0007_0402, 1'b1, 7'd5,  1'b0, 1'b1};
    vecs[2] = '{64'h0,                   1'b0, 7'd0,  1'b1, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd64, 1'b0, 1'b0};
    vecs[4] = '{64'h0000_0018_1800_0000, 1'b0, 7'd4,  1'b0, 1'b0};
    vecs[5] = '{64'h0000_0018_1800_0000, 1'b0, 7'd4,  1'b0, 1'b1};
    vecs[6] = '{64'h0000_0000_0007_0402, 1'b0, 7'd5,  1'b0, 1'b0};

    reset_n     = 1'b0;
    grid        = '0;
    grid_valid  = 1'b0;
    row_ready   = 1'b0;
    overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_frame_pop", 64'(frame_pop), 64'd0);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_overrun",   64'(overrun),   64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i].g, vecs[i].toggle, -1, 1'b0,
                vecs[i].pop, vecs[i].ext, vecs[i].stb);
    end

    // grid_valid while busy sets overrun; frame unaffected
    run_frame(64'h0000_0018_1800_0000, 1'b0, 3, 1'b0,
              7'd4, 1'b0, 1'b0);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    // clear with simultaneous set: set wins
    run_frame(64'h0000_0018_1800_0000, 1'b0, 2, 1'b1,
              7'd4, 1'b0, 1'b1);
    chk("overrun_set_wins", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_clr", 64'(overrun), 64'd0);

    // reset while row 3 is offered
    grid       = 64'h0000_0000_0007_0402;
    grid_valid = 1'b1;
    @(negedge clk);
    grid_valid = 1'b0;
    row_ready  = 1'b1;
    k = 0;
    while (!(row_valid && row_idx == 3'd3) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_row3", 64'(row_idx), 64'd3);
    row_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_row_valid", 64'(row_valid), 64'd0);
    chk("mid_rst_busy",      64'(busy),      64'd0);
    chk("mid_rst_frame_pop", 64'(frame_pop), 64'd0);
    chk("mid_rst_row_data",  64'(row_data),  64'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    row_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pop_valid || row_valid) k++;
    end
    chk("no_activity_after_rst", 64'(k), 64'd0);
    row_ready = 1'b0;
    run_frame(64'h0000_0000_0007_0402, 1'b0, -1, 1'b0,
              7'd5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
